// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the 5x5 router switch allocator and crossbar.
package switch_allocator_pkg;

  localparam int unsigned N_PORTS = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CODE_W  = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_e;

  // Crossbar single-connection code: out*N_PORTS + in.
  function automatic logic [CODE_W-1:0] xbar_code(input logic [IDX_W-1:0] out_idx,
                                                 input logic [IDX_W-1:0] in_idx);
    return CODE_W'(out_idx) * CODE_W'(N_PORTS) + CODE_W'(in_idx);
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(N_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/switch_allocator_rr.sv
// Five-way round-robin pick: first set request at or after ptr, wrapping 4 -> 0.
module rr_arbiter_5
  import switch_allocator_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               found
);

  function automatic logic [IDX_W-1:0] offset_idx(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= int'(N_PORTS)) s = s - int'(N_PORTS);
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
      if (req[offset_idx(ptr, k)]) begin
        grant = offset_idx(ptr, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin with wormhole locking, one new connection per cycle.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_valid,
  input  logic [N_PORTS*IDX_W-1:0]   req_dest,
  input  logic [N_PORTS-1:0]         req_tail,
  input  logic [N_PORTS-1:0]         out_ready,
  output logic [N_PORTS-1:0]         in_ready,
  output logic [N_PORTS-1:0]         out_valid,
  output logic [N_PORTS*IDX_W-1:0]   sel,
  output logic                       cfg_valid,
  output logic [CODE_W-1:0]          cfg_code,
  output logic                       err
);

  lock_e            lock_q   [N_PORTS];
  logic [IDX_W-1:0] owner_q  [N_PORTS];
  logic [IDX_W-1:0] rr_ptr_q [N_PORTS];
  logic [IDX_W-1:0] out_ptr_q;

  logic [N_PORTS-1:0] xfer_c, busy_c, bad_c, out_req_c, in_req_c;
  logic [N_PORTS-1:0] elig_c [N_PORTS];
  logic [IDX_W-1:0]   win_out, win_in;
  logic               out_found, in_found, alloc_c;

  // Transfers through locked connections and which inputs are already bound.
  always_comb begin
    xfer_c   = '0;
    busy_c   = '0;
    bad_c    = '0;
    in_ready = '0;
    for (int o = 0; o < int'(N_PORTS); o++) begin
      if (lock_q[o] == LOCKED) begin
        busy_c[owner_q[o]] = 1'b1;
        xfer_c[o]          = req_valid[owner_q[o]] & out_ready[o];
        if (xfer_c[o]) in_ready[owner_q[o]] = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_PORTS); i++) begin
      bad_c[i] = req_valid[i] && (req_dest[IDX_W*i +: IDX_W] > IDX_W'(N_PORTS - 1));
    end
  end

  always_comb begin
    out_req_c = '0;
    for (int o = 0; o < int'(N_PORTS); o++) begin
      elig_c[o] = '0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        elig_c[o][i] = (lock_q[o] == IDLE) && req_valid[i] && !busy_c[i] &&
                       (req_dest[IDX_W*i +: IDX_W] == IDX_W'(o));
      end
      out_req_c[o] = |elig_c[o];
    end
  end

  rr_arbiter_5 u_out_arb (
    .req   (out_req_c),
    .ptr   (out_ptr_q),
    .grant (win_out),
    .found (out_found)
  );

  assign in_req_c = elig_c[win_out];

  rr_arbiter_5 u_in_arb (
    .req   (in_req_c),
    .ptr   (rr_ptr_q[win_out]),
    .grant (win_in),
    .found (in_found)
  );

  assign alloc_c   = out_found & in_found;
  assign out_valid = xfer_c;

  for (genvar o = 0; o < int'(N_PORTS); o++) begin : g_sel
    assign sel[IDX_W*o +: IDX_W] = owner_q[o];
  end

  // Lock/owner state: release on tail transfer, then at most one allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < int'(N_PORTS); o++) begin
        lock_q[o]   <= IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end
      out_ptr_q <= '0;
      cfg_valid <= 1'b0;
      cfg_code  <= '0;
      err       <= 1'b0;
    end else begin
      for (int o = 0; o < int'(N_PORTS); o++) begin
        if (xfer_c[o] && req_tail[owner_q[o]]) lock_q[o] <= IDLE;
      end
      cfg_valid <= alloc_c;
      if (alloc_c) begin
        lock_q[win_out]   <= LOCKED;
        owner_q[win_out]  <= win_in;
        rr_ptr_q[win_out] <= wrap_inc(win_in);
        out_ptr_q         <= wrap_inc(win_out);
        cfg_code          <= xbar_code(win_out, win_in);
      end
      if (|bad_c) err <= 1'b1;
    end
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Control-side counterpart of the 5x5 router crossbar. Decides which input port drives each output port.
- Per-output round-robin arbitration; wormhole locking: a connection is held from head flit to tail flit.
- Drives per-output select vectors, per-input ready and per-output valid.
- Also emits the single-connection select code in the crossbar's encoding (code = out_port*5 + in_port, range 0..24).

Parameters:
- N_PORTS, 5, number of input and output ports; fixed at 5 because the crossbar code encoding depends on it.
- IDX_W, 3, width of a port index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  5  input i holds a flit.
- req_dest  input  15  requested output per input; bits [3i+2:3i]; valid values 0..4.
- req_tail  input  5  flit at input i is a tail; a head+tail is a single-flit packet.
- out_ready  input  5  downstream of output o can accept a flit.
- in_ready  output  5  flit at input i transfers this cycle.
- out_valid  output  5  output o carries a flit this cycle.
- sel  output  15  input index driving output o; bits [3o+2:3o].
- cfg_valid  output  1  one-cycle pulse: a new connection was established.
- cfg_code  output  6  crossbar code of the newest connection, o*5+i.
- err  output  1  sticky flag: a request with req_dest > 4 was seen.

Behaviour:
- Per-output state:
  - lock: IDLE or LOCKED.
  - owner[o], IDX_W bits.
  - rr_ptr[o], 0..4.
- Global state: out_ptr, 0..4, rotating priority for choosing which idle output allocates.
- Reset values:
  - All outputs 0. sel = 0, cfg_code = 0.
  - All locks IDLE; owners 0; rr_ptr 0; out_ptr 0; err 0.
- Eligibility: input i is eligible for output o when all of the following hold:
  - req_valid[i] = 1 and req_dest[i] = o.
  - Input i owns no LOCKED output.
  - Output o is IDLE.
- Allocation (registered):
  - At most one new connection per cycle.
  - Pick the first idle output with an eligible input, scanning ascending from out_ptr, mod 5.
  - For that output, pick the winner w: the first eligible input scanning ascending from rr_ptr[o], mod 5.
  - Next cycle: lock[o] = LOCKED, owner[o] = w, sel[o] = w, rr_ptr[o] = (w+1) mod 5, out_ptr = (o+1) mod 5.
  - Next cycle also: cfg_valid = 1 and cfg_code = o*5+w.
  - Latency: request at cycle t on an idle output gives connection visible at t+1. An earliest transfer is therefore at t+1.
- Transfer (combinational from state):
  - For LOCKED output o with owner w: out_valid[o] = req_valid[w] & out_ready[o].
  - in_ready[w] = that same value.
  - No other input sees in_ready.
- Release:
  - A transfer with req_tail[w] = 1 sets lock[o] = IDLE next cycle.
  - Output o cannot be reallocated in the release cycle; this is a one-cycle bubble.
  - sel[o] holds its last value while IDLE.
- cfg_valid is 0 in cycles with no new connection; cfg_code holds its last value.
- Invalid destination:
  - req_valid[i] with req_dest[i] > 4 never allocates and never gets in_ready.
  - It sets err = 1 next cycle; err clears only on rst.
- Boundary conditions:
  - Pointers wrap 4 -> 0.
  - req_valid dropping while LOCKED stalls the connection without releasing it.
  - out_ready low stalls with no state change.
  - A single-flit packet allocates, transfers, then releases.
  - Reset asserted mid-packet drops all connections on that edge; in_ready and out_valid are 0 the following cycle.

Decomposition:
- Shared package:
  - N_PORTS and IDX_W.
  - IDLE/LOCKED state encoding.
  - A function for crossbar code = out*N_PORTS+in, also used by the crossbar's bench.
- One natural sub-module, rr_arbiter_5: 5-bit request vector plus 3-bit pointer in, grant index plus found flag out.
  - Instantiated once to pick the output (from out_ptr).
  - Instantiated once to pick the winning input (from rr_ptr of the chosen output).

Test Plan:
- Reset then input 2 requests dest 3, tail=1, out_ready=all ones:
  - Cycle 1: sel[3] = 2, cfg_valid = 1, cfg_code = 17, in_ready[2] = 1, out_valid[3] = 1.
  - Cycle 2: output 3 IDLE.
- Inputs 0, 1, 4 all request dest 0 with single-flit packets held continuously:
  - Grants in order 0, 1, 4, 0.
  - One bubble cycle after each tail.
  - cfg_code sequence 0, 1, 4, 0.
- Input 1 sends a 4-flit packet to dest 2; input 3 requests dest 2 from cycle 1:
  - Input 3 receives no in_ready until the cycle after input 1's tail transfers.
  - Then cfg_code = 13.
- Inputs 0 and 1 request dests 1 and 4 in the same cycle with out_ptr = 0:
  - Output 1 allocates first (cfg_code = 5).
  - Output 4 allocates the next cycle (cfg_code = 21).
- A locked packet stalls with out_ready[o] = 0 for 3 cycles and no state change, then completes.
- Reset asserted mid-packet clears in_ready and out_valid the following cycle.
- Input 2 requests dest 6:
  - err = 1 next cycle and stays set.
  - No in_ready, no cfg_valid.
  - err clears only on rst.
